// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar-lander pushbutton input block:
// FSM states, display-select codes, key indices and the key priority encoder.
package ll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } ll_state_e;

  typedef enum logic [1:0] {
    DISP_ALT  = 2'd0,
    DISP_VEL  = 2'd1,
    DISP_FUEL = 2'd2,
    DISP_THR  = 2'd3
  } disp_sel_e;

  localparam int NUM_PB = 21;

  localparam logic [4:0] KEY_W = 5'd16;
  localparam logic [4:0] KEY_X = 5'd17;
  localparam logic [4:0] KEY_Y = 5'd18;
  localparam logic [4:0] KEY_Z = 5'd19;
  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;

  // Digits pb[9:0] and letters pb[19:16] are live; everything else reads as zero.
  localparam logic [NUM_PB-1:0] KEY_MASK = 21'h0F_03FF;

  // Highest set index wins; returns 0 for an all-zero vector.
  function automatic logic [4:0] prio_enc(input logic [NUM_PB-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ll_sync2.sv
// Two-flop synchronizer for a vector of asynchronous inputs, synchronous reset.
module ll_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ll_input.sv
// Pushbutton front end: synchronize, mask, priority-encode and debounce the
// keypad, then emit one strobe per press and apply the thrust/display action.
module ll_input
  import ll_pkg::*;
#(
  parameter int          DEBOUNCE    = 3,
  parameter logic [15:0] THRUST_INIT = 16'h0005
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  output logic [4:0]  keycode,
  output logic        strobe,
  output logic [15:0] thrust_n,
  output logic        thrust_we,
  output logic [1:0]  disp_sel,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [NUM_PB-1:0] pb_sync;
  logic [NUM_PB-1:0] pb_masked;
  logic              key_valid;
  logic [4:0]        key_code;

  ll_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  cand_q, cand_d;
  logic [4:0]  keycode_q, keycode_d;
  logic        strobe_q, strobe_d;
  logic        thrust_we_q, thrust_we_d;
  logic [15:0] thrust_q, thrust_d;
  disp_sel_e   disp_q, disp_d;

  ll_sync2 #(.W(NUM_PB)) u_sync (
    .clk_i (hz100),
    .rst_i (reset),
    .d_i   (pb),
    .q_o   (pb_sync)
  );

  assign pb_masked = pb_sync & KEY_MASK;
  assign key_valid = |pb_masked;
  assign key_code  = prio_enc(pb_masked);

  // strobe/thrust_we are single-cycle pulses; keycode, thrust_n and disp_sel hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    keycode_d   = keycode_q;
    strobe_d    = 1'b0;
    thrust_we_d = 1'b0;
    thrust_d    = thrust_q;
    disp_d      = disp_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (key_valid) begin
          cand_d  = key_code;
          cnt_d   = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (!key_valid) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key_code != cand_q) begin
          cand_d = key_code;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d     = '0;
          state_d   = ST_HELD;
          keycode_d = cand_q;
          strobe_d  = 1'b1;
          if (cand_q <= KEY_DIGIT_MAX) begin
            thrust_d    = {12'h000, cand_q[3:0]};
            thrust_we_d = 1'b1;
          end else begin
            case (cand_q)
              KEY_Z:   disp_d = DISP_ALT;
              KEY_Y:   disp_d = DISP_VEL;
              KEY_X:   disp_d = DISP_FUEL;
              KEY_W:   disp_d = DISP_THR;
              default: disp_d = disp_q;
            endcase
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Any key activity while held, including a new key, is deliberately ignored.
      ST_HELD: begin
        if (!key_valid) begin
          cnt_d   = CNT_ONE;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (key_valid) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      keycode_q   <= '0;
      strobe_q    <= 1'b0;
      thrust_we_q <= 1'b0;
      thrust_q    <= THRUST_INIT;
      disp_q      <= DISP_ALT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      keycode_q   <= keycode_d;
      strobe_q    <= strobe_d;
      thrust_we_q <= thrust_we_d;
      thrust_q    <= thrust_d;
      disp_q      <= disp_d;
    end
  end

  assign keycode   = keycode_q;
  assign strobe    = strobe_q;
  assign thrust_we = thrust_we_q;
  assign thrust_n  = thrust_q;
  assign disp_sel  = disp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ll_input.sv
// Directed bench for ll_input: latency, key actions, glitch rejection,
// hold/release behaviour and reset during a pending press.
module tb_ll_input;
  import ll_pkg::*;

  logic        hz100;
  logic        reset;
  logic [20:0] pb;
  logic [4:0]  keycode;
  logic        strobe;
  logic [15:0] thrust_n;
  logic        thrust_we;
  logic [1:0]  disp_sel;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_bad;
  int n_strobe;
  int n_we;

  ll_input #(.DEBOUNCE(3), .THRUST_INIT(16'h0005)) dut (
    .hz100     (hz100),
    .reset     (reset),
    .pb        (pb),
    .keycode   (keycode),
    .strobe    (strobe),
    .thrust_n  (thrust_n),
    .thrust_we (thrust_we),
    .disp_sel  (disp_sel),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // driver tasks: advance one edge, sample 1 time unit later
  task automatic tick();
    @(posedge hz100);
    #1;
    if (strobe) n_strobe++;
    if (thrust_we) n_we++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pb    = '0;
    run(2);
    reset    = 1'b0;
    n_strobe = 0;
    n_we     = 0;
  endtask

  task automatic press(input int idx, input int hold, input int gap);
    pb = 21'(1) << idx;
    run(hold);
    pb = '0;
    run(gap);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_strobe = 0; n_we = 0;
    reset = 1'b1;
    pb    = '0;
    run(3);
    check("rst_keycode",   32'(keycode),   32'd0);
    check("rst_strobe",    32'(strobe),    32'd0);
    check("rst_thrust_we", 32'(thrust_we), 32'd0);
    check("rst_thrust_n",  32'(thrust_n),  32'h0005);
    check("rst_disp_sel",  32'(disp_sel),  32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    n_strobe = 0; n_we = 0;

    // pb[7]: strobe lands after edge 5 and lasts one cycle
    pb = 21'(1) << 7;
    run(5);
    check("lat_early_strobe", 32'(strobe), 32'd0);
    tick();
    check("lat_strobe",    32'(strobe),    32'd1);
    check("lat_keycode",   32'(keycode),   32'd7);
    check("lat_thrust_n",  32'(thrust_n),  32'h0007);
    check("lat_thrust_we", 32'(thrust_we), 32'd1);
    tick();
    check("lat_strobe_off", 32'(strobe),    32'd0);
    check("lat_we_off",     32'(thrust_we), 32'd0);
    check("lat_state_held", 32'(dbg_state), 32'(ST_HELD));
    run(3);
    pb = '0;
    run(10);
    check("p7_strobes", 32'(n_strobe), 32'd1);
    check("p7_we",      32'(n_we),     32'd1);
    check("p7_idle",    32'(dbg_state), 32'(ST_IDLE));

    // pb[18] (Y): velocity display, thrust untouched
    do_reset();
    press(18, 10, 10);
    check("y_disp_sel", 32'(disp_sel), 32'd1);
    check("y_keycode",  32'(keycode),  32'd18);
    check("y_we",       32'(n_we),     32'd0);
    check("y_thrust_n", 32'(thrust_n), 32'h0005);
    check("y_strobes",  32'(n_strobe), 32'd1);

    // 2-cycle glitch on pb[3] is rejected
    n_strobe = 0;
    press(3, 2, 10);
    check("glitch_strobes", 32'(n_strobe), 32'd0);
    check("glitch_keycode", 32'(keycode),  32'd18);
    check("glitch_thrust",  32'(thrust_n), 32'h0005);
    check("glitch_disp",    32'(disp_sel), 32'd1);

    // masked buttons never register
    press(12, 10, 10);
    press(20, 10, 10);
    check("masked_strobes", 32'(n_strobe), 32'd0);
    check("masked_keycode", 32'(keycode),  32'd18);

    // remaining letter keys
    press(16, 10, 10);
    check("w_disp_sel", 32'(disp_sel), 32'd3);
    press(17, 10, 10);
    check("x_disp_sel", 32'(disp_sel), 32'd2);
    press(19, 10, 10);
    check("z_disp_sel", 32'(disp_sel), 32'd0);
    check("z_keycode",  32'(keycode),  32'd19);

    // pb[2]+pb[9]: highest wins; adding pb[19] while held is ignored
    n_strobe = 0;
    pb = (21'(1) << 2) | (21'(1) << 9);
    run(10);
    check("prio_keycode", 32'(keycode),  32'd9);
    check("prio_thrust",  32'(thrust_n), 32'h0009);
    check("prio_strobes", 32'(n_strobe), 32'd1);
    pb = pb | (21'(1) << 19);
    run(10);
    check("add_z_strobes", 32'(n_strobe), 32'd1);
    check("add_z_disp",    32'(disp_sel), 32'd0);
    check("add_z_keycode", 32'(keycode),  32'd9);
    pb = '0;
    run(10);

    // long hold then re-press: two strobes
    n_strobe = 0;
    press(4, 50, 10);
    press(4, 10, 10);
    check("repress_strobes", 32'(n_strobe), 32'd2);
    check("repress_keycode", 32'(keycode),  32'd4);
    check("repress_thrust",  32'(thrust_n), 32'h0004);

    // 1-cycle release gap: still one press
    n_strobe = 0;
    press(4, 10, 1);
    press(4, 10, 10);
    check("gap1_strobes", 32'(n_strobe), 32'd1);

    // reset during DEBOUNCE of pb[6]; button stays held through reset
    do_reset();
    pb = 21'(1) << 6;
    run(3);
    check("mid_deb_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_strobe", 32'(strobe),    32'd0);
    check("mid_rst_thrust", 32'(thrust_n),  32'h0005);
    check("mid_rst_state",  32'(dbg_state), 32'(ST_IDLE));
    n_strobe = 0;
    run(5);
    check("after_rst_early", 32'(n_strobe), 32'd0);
    tick();
    check("after_rst_strobe",  32'(strobe),   32'd1);
    check("after_rst_keycode", 32'(keycode),  32'd6);
    check("after_rst_thrust",  32'(thrust_n), 32'h0006);

    // reset while HELD, button still down: accepted again as a new press
    run(4);
    n_strobe = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("held_rst_thrust", 32'(thrust_n), 32'h0005);
    run(6);
    check("held_rst_strobes", 32'(n_strobe), 32'd1);
    check("held_rst_thrust2", 32'(thrust_n), 32'h0006);
    pb = '0;
    run(10);
    check("final_strobes", 32'(n_strobe), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ll_input.md
LL_INPUT -- requirements
Module: ll_input

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, meaning the number of consecutive stable samples required to accept a press or a release.
REQ-002 SHALL have parameter THRUST_INIT, default 16'h0005, meaning the BCD thrust value loaded at reset.
REQ-003 SHALL have port hz100, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port pb, input, 21, raw asynchronous pushbuttons.
REQ-006 SHALL have port keycode, output, 5, the index of the accepted button, held until the next accepted press.
REQ-007 SHALL have port strobe, output, 1, a one-cycle pulse on each accepted press.
REQ-008 SHALL have port thrust_n, output, 16, held BCD thrust: {12'h000, digit}.
REQ-009 SHALL have port thrust_we, output, 1, a one-cycle pulse when thrust_n changes due to a digit press.
REQ-010 SHALL have port disp_sel, output, 2, held display select: 0=altitude, 1=velocity, 2=fuel, 3=thrust.

Function
REQ-011 SHALL pass pb through a two-flop synchronizer; only the synchronized value is used downstream.
REQ-012 SHALL mask pb[15:10] and pb[20] to zero; only pb[9:0] (digits) and pb[19:16] (Z,Y,X,W) are valid keys.
REQ-013 SHALL priority-encode the masked vector, highest index wins; "no key" means the masked vector is zero.
REQ-014 SHALL implement the FSM states IDLE, DEBOUNCE, HELD and RELEASE.
REQ-015 In IDLE, a nonzero key SHALL latch the candidate code, set cnt=1 and go to DEBOUNCE.
REQ-016 In DEBOUNCE with the same code and cnt<DEBOUNCE, cnt SHALL increment.
REQ-017 In DEBOUNCE, a different nonzero code SHALL relatch the candidate with cnt=1; zero SHALL return to IDLE with no strobe.
REQ-018 In DEBOUNCE with the same code and cnt==DEBOUNCE, the FSM SHALL go to HELD, and on that edge it SHALL register keycode, assert strobe and apply the key action.
REQ-019 The key action for a digit d (pb[d]) SHALL be thrust_n<={12'h000,d} with thrust_we=1.
REQ-020 The key action for pb[19]/[18]/[17]/[16] (Z/Y/X/W) SHALL be disp_sel<=0/1/2/3, with thrust_we staying 0.
REQ-021 In HELD, zero input SHALL go to RELEASE with cnt=1; any nonzero input (including a new key) SHALL be ignored.
REQ-022 In RELEASE, zero SHALL increment cnt and return to IDLE at cnt==DEBOUNCE; nonzero SHALL go back to HELD.
REQ-023 Latency SHALL be fixed: for a clean press with pb high before edge 0, strobe is high in the cycle after edge DEBOUNCE+2 (default: after edge 5) and lasts exactly one cycle.
REQ-024 At most one strobe SHALL occur per press-release cycle, however long the button is held.
REQ-025 strobe and thrust_we SHALL be registered outputs, never combinational from pb.
REQ-026 cnt width SHALL be $clog2(DEBOUNCE+1), and cnt SHALL saturate without wrapping.

Reset
REQ-027 When reset is high at an edge, the block SHALL set: state=IDLE, cnt=0, synchronizer flops=0, keycode=0, strobe=0, thrust_we=0, thrust_n=THRUST_INIT, disp_sel=0.
REQ-028 Reset asserted mid-debounce or while HELD SHALL discard the pending press with no strobe; a button still held after reset SHALL be accepted as a new press.

Structure
REQ-029 Package ll_pkg SHALL hold the FSM state enum, the disp_sel enum (DISP_ALT, DISP_VEL, DISP_FUEL, DISP_THR) and the key-index constants KEY_W=16, KEY_X=17, KEY_Y=18, KEY_Z=19.
REQ-030 There SHALL be one sub-module, ll_sync2, a parameterized-width two-flop synchronizer with synchronous reset.

Verification
REQ-031 Press pb[7] for 10 cycles after reset -> single strobe at the latency of REQ-023, keycode=5'd7, thrust_n=16'h0007, thrust_we pulse.
REQ-032 Press pb[18] -> disp_sel=1, keycode=5'd18, thrust_we stays 0, thrust_n unchanged (16'h0005).
REQ-033 pb[3] high for 2 cycles then low (a glitch shorter than DEBOUNCE) -> no strobe, all outputs unchanged.
REQ-034 Hold pb[2] and pb[9] together -> keycode=9, thrust_n=16'h0009; then add pb[19] while held -> no second strobe.
REQ-035 Hold pb[4] for 50 cycles, release, then press pb[4] again -> exactly two strobes; a 1-cycle release gap -> only one strobe.
REQ-036 Assert reset during DEBOUNCE of pb[6] -> no strobe, thrust_n=16'h0005; with pb[6] still held after reset -> strobe at DEBOUNCE+3 cycles after reset deasserts.
